// File: rtl/switch_debounce_toggle_pkg.sv
// switch_debounce_toggle_pkg: shared Go Board clock, debounce and LED blink constants
package switch_debounce_toggle_pkg;
  localparam int CLK_HZ = 25_000_000;
  localparam int DEBOUNCE_LIMIT = CLK_HZ / 100;
  localparam int NUM_SW = 4;
  typedef logic [NUM_SW-1:0] sw_vec_t;
  function automatic int blink_half_period(input int hz);
    return CLK_HZ / (2 * hz);
  endfunction
  localparam int BLINK_HALF_1 = blink_half_period(2);
  localparam int BLINK_HALF_2 = blink_half_period(4);
  localparam int BLINK_HALF_3 = blink_half_period(8);
  localparam int BLINK_HALF_4 = blink_half_period(16);
endpackage

// File: rtl/switch_debounce_toggle_if.sv
// switch_debounce_toggle_if: raw switches in, debounced levels/pulses/LED enables out
interface switch_debounce_toggle_if;
  import switch_debounce_toggle_pkg::*;
  sw_vec_t i_Switch;
  sw_vec_t o_Switch_Db;
  sw_vec_t o_Press;
  sw_vec_t o_Release;
  sw_vec_t o_LED_En;
  modport master(output i_Switch, input o_Switch_Db, o_Press, o_Release, o_LED_En);
  modport slave(input i_Switch, output o_Switch_Db, o_Press, o_Release, o_LED_En);
endinterface

// File: rtl/switch_debounce_toggle_debounce_filter.sv
// debounce_filter: one channel of sync, stability counter, edge pulses and release-toggled enable
module debounce_filter #(
  parameter int   g_DEBOUNCE_LIMIT = 250000,
  parameter logic g_EN_INIT = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Switch_Db,
  output logic o_Press,
  output logic o_Release,
  output logic o_LED_En
);
  localparam int W = $clog2(g_DEBOUNCE_LIMIT + 1);
  localparam logic [W-1:0] LIMIT = W'(g_DEBOUNCE_LIMIT);
  if (g_DEBOUNCE_LIMIT < 1) begin : g_bad_limit
    $error("g_DEBOUNCE_LIMIT must be >= 1");
  end
  logic r_Sync1, r_Sync2;
  logic [W-1:0] count;
  logic accept;
  assign accept = (r_Sync2 != o_Switch_Db) && (count == LIMIT);
  // any cycle where the synchronised level matches the state restarts the window
  always_ff @(posedge i_Clk or posedge i_Rst)
    if (i_Rst) begin
      r_Sync1     <= 1'b0;
      r_Sync2     <= 1'b0;
      count       <= '0;
      o_Switch_Db <= 1'b0;
      o_Press     <= 1'b0;
      o_Release   <= 1'b0;
      o_LED_En    <= g_EN_INIT;
    end else begin
      r_Sync1     <= i_Switch;
      r_Sync2     <= r_Sync1;
      count       <= (r_Sync2 == o_Switch_Db || accept) ? '0 : count + 1'b1;
      o_Switch_Db <= accept ? r_Sync2 : o_Switch_Db;
      o_Press     <= accept && r_Sync2;
      o_Release   <= accept && !r_Sync2;
      o_LED_En    <= (accept && !r_Sync2) ? !o_LED_En : o_LED_En;
    end
endmodule

// File: rtl/switch_debounce_toggle.sv
// switch_debounce_toggle: four independent debounce channels driving LED enables
module switch_debounce_toggle
  import switch_debounce_toggle_pkg::*;
#(
  parameter int      g_DEBOUNCE_LIMIT = DEBOUNCE_LIMIT,
  parameter sw_vec_t g_EN_INIT = '1
) (
  input logic i_Clk,
  input logic i_Rst,
  switch_debounce_toggle_if.slave bus
);
  for (genvar n = 0; n < NUM_SW; n++) begin : g_ch
    debounce_filter #(
      .g_DEBOUNCE_LIMIT(g_DEBOUNCE_LIMIT),
      .g_EN_INIT(g_EN_INIT[n])
    ) u_filter (
      .i_Clk(i_Clk),
      .i_Rst(i_Rst),
      .i_Switch(bus.i_Switch[n]),
      .o_Switch_Db(bus.o_Switch_Db[n]),
      .o_Press(bus.o_Press[n]),
      .o_Release(bus.o_Release[n]),
      .o_LED_En(bus.o_LED_En[n])
    );
  end
endmodule

// File: tb/tb_switch_debounce_toggle.sv
// tb_switch_debounce_toggle: scoreboard of expected press/release events checked every cycle
module tb_switch_debounce_toggle;
  localparam int LIM = 4;
  localparam int LAT = 3 + LIM;
  typedef struct {
    int cyc;
    logic [3:0] press;
    logic [3:0] rel;
  } ev_t;
  logic i_Clk = 1'b0;
  logic i_Rst = 1'b0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  ev_t sb[$];
  ev_t ev;
  logic [3:0] exp_db = '0, exp_led = 4'b1111, exp_press, exp_rel;
  switch_debounce_toggle_if bus();
  switch_debounce_toggle #(.g_DEBOUNCE_LIMIT(LIM), .g_EN_INIT(4'b1111)) dut (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .bus(bus)
  );
  always #5 i_Clk = ~i_Clk;
  always @(posedge i_Clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at cycle %0d", tag, got, want, cyc);
    end
  endtask
  always @(negedge i_Clk)
    if (!mon_en) begin
      exp_db  = '0;
      exp_led = 4'b1111;
    end else begin
      exp_press = '0;
      exp_rel   = '0;
      while (sb.size() != 0 && sb[0].cyc == cyc) begin
        ev = sb.pop_front();
        exp_press |= ev.press;
        exp_rel   |= ev.rel;
      end
      exp_db  = (exp_db | exp_press) & ~exp_rel;
      exp_led = exp_led ^ exp_rel;
      check("press", bus.o_Press, exp_press);
      check("release", bus.o_Release, exp_rel);
      check("db", bus.o_Switch_Db, exp_db);
      check("led_en", bus.o_LED_En, exp_led);
    end
  task automatic step(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask
  task automatic set_sw(input logic [3:0] v, input bit accepted);
    logic [3:0] d = v ^ bus.i_Switch;
    bus.i_Switch = v;
    if (accepted) sb.push_back('{cyc + LAT, d & v, d & ~v});
  endtask
  task automatic reset_pulse();
    i_Rst  = 1'b1;
    mon_en = 1'b0;
    sb.delete();
    #1;
    check("rst_db", bus.o_Switch_Db, 4'b0000);
    check("rst_press", bus.o_Press, 4'b0000);
    check("rst_release", bus.o_Release, 4'b0000);
    check("rst_led_en", bus.o_LED_En, 4'b1111);
    step(2);
    i_Rst  = 1'b0;
    mon_en = 1'b1;
  endtask
  initial begin
    bus.i_Switch = '0;
    #12 reset_pulse();
    step(3);
    set_sw(4'b0001, 1'b1);
    step(10);
    set_sw(4'b0000, 1'b1);
    step(10);
    set_sw(4'b0010, 1'b0);
    step(3);
    set_sw(4'b0000, 1'b0);
    step(10);
    set_sw(4'b0010, 1'b0);
    step(LIM);
    set_sw(4'b0000, 1'b0);
    step(10);
    set_sw(4'b0010, 1'b1);
    step(LIM + 1);
    set_sw(4'b0000, 1'b1);
    step(12);
    for (int i = 0; i < 2; i++) begin
      set_sw(4'b0100, 1'b1);
      step(10);
      set_sw(4'b0000, 1'b1);
      step(10);
    end
    set_sw(4'b1111, 1'b1);
    step(10);
    set_sw(4'b0000, 1'b1);
    step(10);
    set_sw(4'b1000, 1'b0);
    step(5);
    reset_pulse();
    sb.push_back('{cyc + LAT, 4'b1000, 4'b0000});
    step(12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/switch_debounce_toggle.md
# switch_debounce_toggle

Conditions the four Go Board push-button inputs for the LED stage that follows it. Each raw switch is synchronised, debounced by a per-channel stability counter and edge-detected. Each release toggles a per-channel LED enable that gates the corresponding blinking LED output. All logic runs in the single board clock domain.

## Interface
- g_DEBOUNCE_LIMIT, 250000: consecutive synchronised cycles (minus one) a new level must hold before acceptance; 10 ms at 25 MHz; must be ≥1.
- g_EN_INIT, 4'b1111: reset value of o_LED_En.
- i_Clk  in  1  board clock, 25 MHz.
- i_Rst  in  1  reset; asynchronous assert, active-high.
- i_Switch  in  4  raw push-button levels, 1 = pressed; asynchronous to i_Clk; bit n = switch n+1.
- o_Switch_Db  out  4  debounced switch levels.
- o_Press  out  4  one-cycle pulse on debounced 0→1.
- o_Release  out  4  one-cycle pulse on debounced 1→0.
- o_LED_En  out  4  per-channel enable; 1 = LED n+1 allowed to blink.

## Operation
- Per channel: 2-flop synchroniser (r_Sync1 → r_Sync2). Both flops reset to 0.
- Stability counter: width ceil(log2(g_DEBOUNCE_LIMIT+1)). Resets to 0.
  - If r_Sync2 == state: counter <= 0.
  - Else if counter == g_DEBOUNCE_LIMIT: state <= r_Sync2 and counter <= 0.
  - Else: counter <= counter + 1.
- The counter saturates only through the accept path and never wraps.
- A glitch shorter than the acceptance window clears the counter and leaves the state unchanged.
- o_Press is registered and asserted on the same edge that sets state 0→1. It is 0 on every other cycle.
- o_Release is registered and asserted on the same edge that sets state 1→0. It is 0 on every other cycle.
- o_LED_En[n] toggles on the same edge that asserts o_Release[n]. A press alone does not change it.
- Channels are fully independent. Simultaneous events on several channels are each handled in the same cycle.
- Reset values:
  - o_Switch_Db = 0, o_Press = 0, o_Release = 0.
  - o_LED_En = g_EN_INIT.
  - All counters and synchronisers = 0.
- Reset mid-count discards the partial count. A switch that is still held after reset is accepted after a full window, followed by an o_Press pulse.

## Timing
- Latency from a raw edge that is stable from before clock edge 1 to the o_Switch_Db, o_Press or o_Release change: 2 sync edges + (g_DEBOUNCE_LIMIT+1) counting edges. This is edge 2+g_DEBOUNCE_LIMIT+1.
- A pulse width is exactly one i_Clk cycle. The minimum spacing between consecutive events on one channel is g_DEBOUNCE_LIMIT+1 cycles.
- i_Rst asserts outputs immediately, without waiting for a clock edge. De-assertion is expected to be synchronous to i_Clk at board level.

## Structure
- Sub-module debounce_filter: one channel containing synchroniser, counter, state, press/release pulses and the enable toggle flop. It takes g_DEBOUNCE_LIMIT and a 1-bit init value. The top level instantiates it four times with a generate loop.
- Shared package/include for the Go Board projects holds:
  - CLK_HZ = 25000000.
  - Default debounce limit, defined as CLK_HZ/100.
  - Switch/LED count = 4.
- The blink-rate constants used by the LED stage live in the same package.

## Test plan
Use g_DEBOUNCE_LIMIT = 4 and g_EN_INIT = 4'b1111 throughout.
- Reset: assert i_Rst mid-cycle -> all outputs go to 0 at once except o_LED_En = 4'b1111.
- Clean press: i_Switch[0] 0→1 held -> o_Switch_Db[0] = 1 and o_Press[0] = 1 on edge 7 only. Nothing changes on other channels.
- Glitch rejection: i_Switch[1] high for 3 cycles, then low -> o_Switch_Db[1] stays 0 and no pulses occur.
- Release toggles: press then release i_Switch[2], each held ≥10 cycles:
  - o_Release[2] pulses once and o_LED_En[2] goes 1→0.
  - A second press/release returns o_LED_En[2] to 1.
- Simultaneous events: all four switches rise in the same cycle -> o_Press = 4'b1111 for one cycle, 7 edges later.
- Reset mid-count: i_Switch[3] held high and i_Rst pulsed at edge 5 -> no o_Press before reset. o_Press[3] then pulses 7 edges after i_Rst de-asserts, and o_LED_En[3] stays 1.
